// File: rtl/conv_out_serializer_if.sv
// rtl/conv_out_serializer_if.sv - parallel-lane input and serialized output stream bundle
// The slave modport is the serializer's view; the master modport drives lanes and accepts beats.
interface conv_out_serializer_if #(
    parameter int DATA_WIDTH   = 16,
    parameter int KERNEL_W_MAX = 3,
    parameter int TUSER_WIDTH  = 4,
    parameter int LANE_W       = (KERNEL_W_MAX > 1) ? $clog2(KERNEL_W_MAX) : 1
);
    logic [KERNEL_W_MAX-1:0]                  s_valid;
    logic [KERNEL_W_MAX-1:0][DATA_WIDTH-1:0]  s_data;
    logic [KERNEL_W_MAX-1:0]                  s_last;
    logic [KERNEL_W_MAX-1:0][TUSER_WIDTH-1:0] s_user;
    logic                                     m_valid;
    logic                                     m_ready;
    logic [DATA_WIDTH-1:0]                    m_data;
    logic                                     m_last;
    logic [TUSER_WIDTH-1:0]                   m_user;
    logic [LANE_W-1:0]                        m_lane;

    modport slave (
        input  s_valid, s_data, s_last, s_user, m_ready,
        output m_valid, m_data, m_last, m_user, m_lane
    );

    modport master (
        output s_valid, s_data, s_last, s_user, m_ready,
        input  m_valid, m_data, m_last, m_user, m_lane
    );
endinterface

// File: rtl/conv_out_serializer.sv
// rtl/conv_out_serializer.sv - buffers multi-lane beats and emits them one lane per handshake
// Optional drop counter enabled by defining CONV_OUT_SERIALIZER_DROP_CNT_EN.
module conv_out_serializer #(
    parameter int DATA_WIDTH   = 16,
    parameter int KERNEL_W_MAX = 3,
    parameter int TUSER_WIDTH  = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        aclken,
    conv_out_serializer_if.slave        bus,
    output logic                        almost_full,
`ifdef CONV_OUT_SERIALIZER_DROP_CNT_EN
    output logic                        overflow,
    output logic [15:0]                 drop_count
`else
    output logic                        overflow
`endif
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LANE_W = (KERNEL_W_MAX > 1) ? $clog2(KERNEL_W_MAX) : 1;

    logic [KERNEL_W_MAX-1:0][DATA_WIDTH-1:0]  data_mem_q [FIFO_DEPTH];
    logic [KERNEL_W_MAX-1:0][TUSER_WIDTH-1:0] user_mem_q [FIFO_DEPTH];
    logic [KERNEL_W_MAX-1:0]                  mask_mem_q [FIFO_DEPTH];
    logic                                     last_mem_q [FIFO_DEPTH];

    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [KERNEL_W_MAX-1:0] sent_q, sent_d;
    logic                    overflow_q, overflow_d, almost_full_q, almost_full_d;

    logic [KERNEL_W_MAX-1:0] pend, low_bit;
    logic                    not_empty, final_lane, hs, pop, beat, wr, drop;
    logic [LANE_W-1:0]       cur_lane;
    logic [DATA_WIDTH-1:0]   cur_data;
    logic [TUSER_WIDTH-1:0]  cur_user;

    // sent_q marks lanes of the head entry already handed out; the lowest pending lane is next.
    assign not_empty  = (count_q != '0);
    assign pend       = mask_mem_q[rd_ptr_q] & ~sent_q;
    assign low_bit    = pend & (~pend + KERNEL_W_MAX'(1));
    assign final_lane = ((pend & (pend - KERNEL_W_MAX'(1))) == '0);

    always_comb begin
        cur_lane = '0;
        cur_data = '0;
        cur_user = '0;
        for (int i = KERNEL_W_MAX - 1; i >= 0; i--) begin
            if (pend[i]) begin
                cur_lane = LANE_W'(i);
                cur_data = data_mem_q[rd_ptr_q][i];
                cur_user = user_mem_q[rd_ptr_q][i];
            end
        end
    end

    assign bus.m_valid = not_empty & aclken;
    assign bus.m_data  = not_empty ? cur_data : '0;
    assign bus.m_user  = not_empty ? cur_user : '0;
    assign bus.m_lane  = not_empty ? cur_lane : '0;
    assign bus.m_last  = not_empty & final_lane & last_mem_q[rd_ptr_q];
    assign almost_full = almost_full_q;
    assign overflow    = overflow_q;

    // A pop on the same edge frees the slot a full FIFO would otherwise refuse.
    assign hs   = aclken & not_empty & bus.m_ready;
    assign pop  = hs & final_lane;
    assign beat = aclken & (|bus.s_valid);
    assign wr   = beat & ((count_q != CNT_W'(FIFO_DEPTH)) | pop);
    assign drop = beat & ~wr;

    always_comb begin
        wr_ptr_d   = wr  ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q;
        if (wr && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !wr) begin
            count_d = count_q - CNT_W'(1);
        end
        sent_d = sent_q;
        if (hs) begin
            sent_d = pop ? '0 : (sent_q | low_bit);
        end
        overflow_d    = overflow_q | drop;
        almost_full_d = (count_d >= CNT_W'(FIFO_DEPTH - 1));
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            sent_q        <= '0;
            overflow_q    <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            sent_q        <= sent_d;
            overflow_q    <= overflow_d;
            almost_full_q <= almost_full_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (wr && !areset) begin
            data_mem_q[wr_ptr_q] <= bus.s_data;
            user_mem_q[wr_ptr_q] <= bus.s_user;
            mask_mem_q[wr_ptr_q] <= bus.s_valid;
            last_mem_q[wr_ptr_q] <= |(bus.s_last & bus.s_valid);
        end
    end

`ifdef CONV_OUT_SERIALIZER_DROP_CNT_EN
    logic [15:0] drop_count_q, drop_count_d;

    assign drop_count_d = (drop && drop_count_q != 16'hFFFF) ? drop_count_q + 16'd1 : drop_count_q;
    assign drop_count   = drop_count_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end
`endif
endmodule

// File: doc/conv_out_serializer.md
CONV_OUT_SERIALIZER -- requirements
Module: conv_out_serializer

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH (default 16), pixel/accumulator data width; KERNEL_W_MAX (3), number of parallel input lanes; TUSER_WIDTH (4), sideband width; FIFO_DEPTH (4), entry buffer depth, a power of two of at least 2.
REQ-002 The block SHALL use one clock, aclk; reset areset SHALL be synchronous and active-high.
REQ-003 Ports SHALL be as follows, one per line:
- aclk  in  1  clock.
- areset  in  1  synchronous active-high reset.
- aclken  in  1  clock enable.
- s_valid  in  [KERNEL_W_MAX]x1  per-lane valid; no ready is returned to the source.
- s_data  in  [KERNEL_W_MAX]xDATA_WIDTH  per-lane data.
- s_last  in  [KERNEL_W_MAX]x1  per-lane last.
- s_user  in  [KERNEL_W_MAX]xTUSER_WIDTH  per-lane user.
- m_valid  out  1  serialized beat valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_WIDTH  serialized data.
- m_last  out  1  end-of-group marker.
- m_user  out  TUSER_WIDTH  lane user.
- m_lane  out  clog2(KERNEL_W_MAX)  source lane index.
- almost_full  out  1  at most one free entry; the source uses it to drop aclken.
- overflow  out  1  sticky drop flag.

Function
REQ-004 Input beat: on an aclk edge with aclken=1 and any s_valid bit set, the block SHALL write one FIFO entry containing all lanes' data, last and user fields plus a lane mask equal to s_valid.
REQ-005 A cycle with all s_valid bits low SHALL write nothing; the FIFO SHALL never hold an empty-mask entry.
REQ-006 Serialization: the head entry SHALL be emitted one lane per handshake (m_valid and m_ready both high) in ascending lane index, skipping masked-off lanes.
REQ-007 m_data, m_user and m_lane SHALL reflect the lane currently being emitted.
REQ-008 m_last SHALL be high only on the highest-indexed valid lane of an entry, and only if any masked-in s_last in that entry was high.
REQ-009 Pop: the head entry SHALL be freed on the handshake of its highest-indexed valid lane; the lane pointer SHALL then return to the lowest valid lane of the next entry.
REQ-010 Latency: an entry written at edge N SHALL present m_valid=1 from the cycle after edge N; there is no combinational path from s_* to m_*.
REQ-011 m_valid SHALL equal (count != 0) AND aclken; when aclken=0, no write, pop, pointer or flag update SHALL occur.
REQ-012 Output stability: while m_valid=1 and m_ready=0, m_data, m_last, m_user and m_lane SHALL hold stable.
REQ-013 Full without pop: a beat arriving with count=FIFO_DEPTH and no pop in the same cycle SHALL be dropped and SHALL set overflow=1.
REQ-014 Full with pop: a beat arriving with count=FIFO_DEPTH while a pop occurs in the same cycle SHALL be accepted, count SHALL stay at FIFO_DEPTH, and overflow SHALL be unchanged.
REQ-015 Pointers: read and write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-016 almost_full SHALL be registered and SHALL equal (count >= FIFO_DEPTH-1) after each edge.

Reset
REQ-017 On areset=1 at an aclk edge, regardless of aclken, the block SHALL clear count, both pointers, the lane pointer and overflow.
REQ-018 Reset SHALL force m_valid=0, m_data=0, m_last=0, m_user=0, m_lane=0 and almost_full=0.
REQ-019 Reset asserted mid-group SHALL discard all buffered lanes; no stale lane SHALL be emitted after reset.
REQ-020 Inputs presented in the reset cycle SHALL be ignored.

Configuration
REQ-021 With CONV_OUT_SERIALIZER_DROP_CNT_EN defined, the block SHALL add output drop_count (16 bits), which increments by one for each dropped entry, saturates at 16'hFFFF, and clears on reset.
REQ-022 With CONV_OUT_SERIALIZER_DROP_CNT_EN undefined, the drop_count port and counter logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-023 Basic serialization: one beat with s_valid=3'b111, data {1000,2000,3000}, s_last=3'b000, m_ready=1 -> m_data 1000, 2000, 3000 with m_lane 0, 1, 2 on consecutive cycles starting the cycle after the write; m_last=0 throughout.
REQ-024 Partial mask with last: s_valid=3'b101, data {5,x,7}, s_last=3'b100 -> exactly two beats, 5 (lane 0) then 7 (lane 2); m_last=1 only on the 7.
REQ-025 Backpressure and overflow: m_ready=0, then 5 consecutive beats -> almost_full=1 after the 3rd, overflow=1 after the 5th, 4 entries retained; m_ready=1 drains 12 beats in order; drop_count=1 when the macro is defined.
REQ-026 Full with pop: count=4 and head on its last lane with m_ready=1, new beat same cycle -> beat accepted, count stays 4, overflow stays 0.
REQ-027 Reset mid-group: areset pulsed after lane 0 of a 3-lane entry is emitted -> m_valid=0 the next cycle, count=0, no remaining lanes emitted.
REQ-028 Clock-enable stall: aclken=0 for 3 cycles mid-drain -> m_valid=0 and outputs frozen; emission resumes at the same lane when aclken returns to 1.
